pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
- Central stall/flush sequencer for the 5-stage core: fetch, decode, execute, memory, write-back.
- Sits beside the forwarding unit, which remains purely combinational.
- Resolves load-use hazards, multi-cycle mul/div occupancy, data-memory wait states and taken-branch flushes into one prioritised set of per-stage stall/flush controls.
- Keeps saturating performance counters for stall cycles and flushes.

Parameters:
- MULDIV_CYCLES, 32: fixed EX-stage occupancy of a mul/div op in cycles; legal range 2..255.
- STALL_CNT_W, 32: width of the stall-cycle counter.
- FLUSH_CNT_W, 16: width of the flush counter.

Ports:
- clk  in  1  core clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_rs1_addr  in  5  rs1 of the instruction in DEC
- dec_rs2_addr  in  5  rs2 of the instruction in DEC
- dec_uses_rs1  in  1  DEC instruction reads rs1
- dec_uses_rs2  in  1  DEC instruction reads rs2
- ex_rd_addr  in  5  rd of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_muldiv_valid  in  1  EX instruction is mul/div
- take_branch  in  1  EX resolved taken branch/jump
- dmem_req  in  1  MEM stage has an active data access
- dmem_ready  in  1  data memory completes the access this cycle
- stall_pc  out  1  hold PC
- stall_fet_dec  out  1  hold IF/ID register
- stall_dec_ex  out  1  hold ID/EX register
- stall_ex_mem  out  1  hold EX/MEM register
- stall_mem_wb  out  1  hold MEM/WB register
- flush_fet_dec  out  1  load NOP into IF/ID
- flush_dec_ex  out  1  load NOP into ID/EX
- flush_ex_mem  out  1  load NOP into EX/MEM
- muldiv_start  out  1  one-cycle start pulse to the mul/div unit
- muldiv_busy  out  1  FSM is in MD_BUSY
- stall_cycles  out  STALL_CNT_W  count of cycles with stall_pc=1, saturating
- flush_count  out  FLUSH_CNT_W  count of cycles with flush_fet_dec=1, saturating

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=RUN, md_cnt=0, stall_cycles=0, flush_count=0.
  - While rst_n is low, every stall/flush output, muldiv_start and muldiv_busy are forced to 0, regardless of inputs.
- FSM states: RUN, MD_BUSY. md_cnt is 8 bits.
- Condition terms (combinational):
  - mem_wait = dmem_req & ~dmem_ready.
  - load_use = ex_mem_read & ex_rd_addr!=0 & ((dec_uses_rs1 & dec_rs1_addr==ex_rd_addr) | (dec_uses_rs2 & dec_rs2_addr==ex_rd_addr)).
- Priority, highest first; outputs not named in the winning rule are 0.
  1. mem_wait: assert stall_pc, stall_fet_dec, stall_dec_ex, stall_ex_mem, stall_mem_wb (full freeze). FSM and md_cnt hold. Branch, load_use and muldiv start are all suppressed.
  2. MD_BUSY, or RUN with ex_muldiv_valid: assert stall_pc, stall_fet_dec, stall_dec_ex, flush_ex_mem (bubble into MEM). MEM/WB continue to drain.
  3. take_branch in RUN: assert flush_fet_dec and flush_dec_ex for one cycle. No stall_pc, so the PC loads the target. A simultaneous load_use is ignored.
  4. load_use in RUN: assert stall_pc, stall_fet_dec, flush_dec_ex for one cycle (single bubble).
- Mul/div sequencing:
  - RUN with ex_muldiv_valid and no mem_wait: muldiv_start=1, md_cnt<=MULDIV_CYCLES-2, next state MD_BUSY.
  - MD_BUSY without mem_wait: md_cnt==0 -> next state RUN, otherwise md_cnt decrements.
  - The mul/div instruction advances on the first RUN cycle. Total stalled cycles = MULDIV_CYCLES.
  - muldiv_busy = (state==MD_BUSY).
  - In the first RUN cycle after MD_BUSY, ex_muldiv_valid is still high for the same instruction. This must not restart the unit: a 1-bit md_done flag, set on the MD_BUSY->RUN transition and cleared on the next unstalled cycle, masks ex_muldiv_valid.
  - A mem_wait arriving during MD_BUSY freezes md_cnt. The stall ends MULDIV_CYCLES non-frozen cycles after the start.
- Counters:
  - stall_cycles increments on each cycle with stall_pc=1 and flush_count on each cycle with flush_fet_dec=1.
  - Both saturate at all-ones; no wrap.
- Async reset during MD_BUSY returns to RUN immediately; the next cycle's outputs are driven purely by the inputs.

Test Plan:
- Load-use: lw x5 in EX, DEC add x6,x5,x1 (dec_uses_rs1=1) -> exactly 1 cycle stall_pc=stall_fet_dec=flush_dec_ex=1, stall_cycles=1. Same case with ex_rd_addr=0 -> no stall.
- Mul/div with MULDIV_CYCLES=4: ex_muldiv_valid held high -> muldiv_start pulses once. stall_pc=1 for exactly 4 cycles, muldiv_busy=1 for 3 of them, then the pipeline advances with no second muldiv_start.
- Mem wait: dmem_req=1, dmem_ready=0 for 3 cycles during MD_BUSY (MULDIV_CYCLES=4) -> all five stalls high for 3 cycles and md_cnt frozen. Total stall_pc cycles = 7.
- Branch vs load-use: take_branch=1 and load_use=1 in the same cycle -> flush_fet_dec=flush_dec_ex=1, stall_pc=0, flush_count=1. Branch during mem_wait -> no flush until dmem_ready=1.
- Saturation: STALL_CNT_W=4, 20 load-use stalls -> stall_cycles stays at 15.
- Reset mid-op: rst_n deasserted in cycle 2 of MD_BUSY -> outputs immediately 0, counters 0. After release with no requests: state RUN, no stall.

Source files
------------

// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: hazard inputs and stall/flush controls between core pipeline and sequencer
interface pipeline_controller_if;
  logic [4:0] dec_rs1_addr;
  logic [4:0] dec_rs2_addr;
  logic       dec_uses_rs1;
  logic       dec_uses_rs2;
  logic [4:0] ex_rd_addr;
  logic       ex_mem_read;
  logic       ex_muldiv_valid;
  logic       take_branch;
  logic       dmem_req;
  logic       dmem_ready;
  logic       stall_pc;
  logic       stall_fet_dec;
  logic       stall_dec_ex;
  logic       stall_ex_mem;
  logic       stall_mem_wb;
  logic       flush_fet_dec;
  logic       flush_dec_ex;
  logic       flush_ex_mem;
  logic       muldiv_start;
  logic       muldiv_busy;
  modport master (
    output dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2, ex_rd_addr,
           ex_mem_read, ex_muldiv_valid, take_branch, dmem_req, dmem_ready,
    input  stall_pc, stall_fet_dec, stall_dec_ex, stall_ex_mem, stall_mem_wb,
           flush_fet_dec, flush_dec_ex, flush_ex_mem, muldiv_start, muldiv_busy
  );
  modport slave (
    input  dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2, ex_rd_addr,
           ex_mem_read, ex_muldiv_valid, take_branch, dmem_req, dmem_ready,
    output stall_pc, stall_fet_dec, stall_dec_ex, stall_ex_mem, stall_mem_wb,
           flush_fet_dec, flush_dec_ex, flush_ex_mem, muldiv_start, muldiv_busy
  );
endinterface

// File: rtl/pipeline_controller.sv
// pipeline_controller: prioritised stall/flush sequencer with mul/div occupancy FSM and perf counters
module pipeline_controller #(
  parameter int MULDIV_CYCLES = 32,
  parameter int STALL_CNT_W   = 32,
  parameter int FLUSH_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_controller_if.slave   pif,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);
  typedef enum logic {RUN, MD_BUSY} state_t;
  state_t     state;
  logic [7:0] md_cnt;
  logic       md_done;
  logic       mem_wait, load_use, busy, md_req, md_stall, br, lu;
  // hazard terms resolved into exactly one winning rule, highest priority first
  always_comb begin
    mem_wait = pif.dmem_req & ~pif.dmem_ready;
    load_use = pif.ex_mem_read & (pif.ex_rd_addr != 5'd0) &
               ((pif.dec_uses_rs1 & (pif.dec_rs1_addr == pif.ex_rd_addr)) |
                (pif.dec_uses_rs2 & (pif.dec_rs2_addr == pif.ex_rd_addr)));
    busy     = (state == MD_BUSY);
    md_req   = busy | (pif.ex_muldiv_valid & ~md_done);
    md_stall = ~mem_wait & md_req;
    br       = ~mem_wait & ~md_req & pif.take_branch;
    lu       = ~mem_wait & ~md_req & ~pif.take_branch & load_use;
  end
  // controls are gated by rst_n so they drop the moment reset asserts
  assign pif.stall_pc      = rst_n & (mem_wait | md_stall | lu);
  assign pif.stall_fet_dec = rst_n & (mem_wait | md_stall | lu);
  assign pif.stall_dec_ex  = rst_n & (mem_wait | md_stall);
  assign pif.stall_ex_mem  = rst_n & mem_wait;
  assign pif.stall_mem_wb  = rst_n & mem_wait;
  assign pif.flush_fet_dec = rst_n & br;
  assign pif.flush_dec_ex  = rst_n & (br | lu);
  assign pif.flush_ex_mem  = rst_n & md_stall;
  assign pif.muldiv_start  = rst_n & md_stall & ~busy;
  assign pif.muldiv_busy   = rst_n & busy;
  // mul/div occupancy: everything freezes under mem_wait; md_done masks the still-valid op for one advancing cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else if (!mem_wait) begin
      md_done <= busy && md_cnt == 8'd0;
      if (busy) begin
        if (md_cnt == 8'd0) state <= RUN;
        else md_cnt <= md_cnt - 8'd1;
      end else if (pif.ex_muldiv_valid && !md_done) begin
        state  <= MD_BUSY;
        md_cnt <= 8'(MULDIV_CYCLES - 2);
      end
    end
  end
  // saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pif.stall_pc && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (pif.flush_fet_dec && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed and random checks against a cycle-count reference model
module tb_pipeline_controller;
  localparam int MD = 4;
  localparam int SW = 4;
  localparam int FW = 16;
  localparam int SMAX = 2**SW - 1;
  localparam int FMAX = 2**FW - 1;
  localparam int SPC = 9, SFD = 8, SDE = 7, SEM = 6, SMW = 5, FFD = 4, FDE = 3, FEM = 2, ST = 1, BSY = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [SW-1:0] stall_cycles;
  logic [FW-1:0] flush_count;
  int checks = 0;
  int failures = 0;
  int m_left, n_left, m_sc, n_sc, m_fc, n_fc, exp_sc, exp_fc;
  bit m_done, n_done;
  logic [9:0] exp_o;
  always #5 clk = ~clk;
  pipeline_controller_if pif();
  pipeline_controller #(.MULDIV_CYCLES(MD), .STALL_CNT_W(SW), .FLUSH_CNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .pif(pif.slave), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  function automatic logic [9:0] act_o();
    return {pif.stall_pc, pif.stall_fet_dec, pif.stall_dec_ex, pif.stall_ex_mem, pif.stall_mem_wb,
            pif.flush_fet_dec, pif.flush_dec_ex, pif.flush_ex_mem, pif.muldiv_start, pif.muldiv_busy};
  endfunction
  task automatic model_clear();
    m_left = 0; n_left = 0; m_sc = 0; n_sc = 0; m_fc = 0; n_fc = 0; m_done = 0; n_done = 0;
    exp_o = '0; exp_sc = 0; exp_fc = 0;
  endtask
  task automatic set_in(input logic [4:0] rs1, rs2, rd, input logic u1, u2, mr, mdv, tb, req, rdy);
    pif.dec_rs1_addr = rs1; pif.dec_rs2_addr = rs2; pif.ex_rd_addr = rd;
    pif.dec_uses_rs1 = u1; pif.dec_uses_rs2 = u2; pif.ex_mem_read = mr;
    pif.ex_muldiv_valid = mdv; pif.take_branch = tb; pif.dmem_req = req; pif.dmem_ready = rdy;
  endtask
  // one cycle: drive at negedge, then evaluate the reference model for this cycle
  task automatic apply(input logic [4:0] rs1, rs2, rd, input logic u1, u2, mr, mdv, tb, req, rdy);
    bit mw, lu;
    @(negedge clk);
    m_left = n_left; m_done = n_done; m_sc = n_sc; m_fc = n_fc;
    set_in(rs1, rs2, rd, u1, u2, mr, mdv, tb, req, rdy);
    #1;
    mw = req && !rdy;
    lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    exp_o = '0;
    exp_o[BSY] = m_left > 0;
    exp_sc = m_sc; exp_fc = m_fc;
    n_left = m_left; n_done = m_done;
    if (mw) begin
      exp_o[SPC] = 1; exp_o[SFD] = 1; exp_o[SDE] = 1; exp_o[SEM] = 1; exp_o[SMW] = 1;
    end else if (m_left > 0 || (mdv && !m_done)) begin
      exp_o[SPC] = 1; exp_o[SFD] = 1; exp_o[SDE] = 1; exp_o[FEM] = 1;
      if (m_left == 0) begin
        exp_o[ST] = 1; n_left = MD - 1; n_done = 0;
      end else begin
        n_left = m_left - 1;
        n_done = (n_left == 0);
      end
    end else begin
      n_done = 0;
      if (tb) begin
        exp_o[FFD] = 1; exp_o[FDE] = 1;
      end else if (lu) begin
        exp_o[SPC] = 1; exp_o[SFD] = 1; exp_o[FDE] = 1;
      end
    end
    n_sc = (exp_o[SPC] && m_sc < SMAX) ? m_sc + 1 : m_sc;
    n_fc = (exp_o[FFD] && m_fc < FMAX) ? m_fc + 1 : m_fc;
  endtask
  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    set_in(5, 5, 5, 1, 1, 1, 1, 1, 1, 0);
    #1;
    checks++;
    if (act_o() !== 10'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", act_o(), 10'd0); end
    checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
    end
    do_reset();
    idle();
    checks++;
    if (act_o() !== exp_o) begin failures++; $display("FAIL reset_idle got=%b exp=%b", act_o(), exp_o); end
  endtask
  task automatic test_load_use();
    do_reset();
    apply(5, 1, 5, 1, 1, 1, 0, 0, 0, 1);
    checks++;
    if (act_o() !== exp_o || act_o() !== 10'b1100_0010_00) begin
      failures++; $display("FAIL load_use got=%b exp=%b", act_o(), exp_o);
    end
    idle();
    checks++;
    if (act_o() !== exp_o || int'(stall_cycles) !== 1) begin
      failures++; $display("FAIL load_use_after got=%b cnt=%0d exp=%b cnt=1", act_o(), stall_cycles, exp_o);
    end
    apply(0, 1, 0, 1, 1, 1, 0, 0, 0, 1);
    checks++;
    if (act_o() !== exp_o || pif.stall_pc !== 1'b0) begin
      failures++; $display("FAIL load_use_x0 got=%b exp=%b", act_o(), exp_o);
    end
    apply(7, 9, 9, 0, 1, 1, 0, 0, 0, 1);
    checks++;
    if (act_o() !== exp_o || pif.flush_dec_ex !== 1'b1) begin
      failures++; $display("FAIL load_use_rs2 got=%b exp=%b", act_o(), exp_o);
    end
  endtask
  task automatic test_muldiv();
    int nstall, nstart, nbusy;
    do_reset();
    nstall = 0; nstart = 0; nbusy = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      else idle();
      checks++;
      if (act_o() !== exp_o) begin failures++; $display("FAIL muldiv_cyc%0d got=%b exp=%b", i, act_o(), exp_o); end
      nstall += int'(pif.stall_pc); nstart += int'(pif.muldiv_start); nbusy += int'(pif.muldiv_busy);
    end
    checks++;
    if (nstall !== 4 || nstart !== 1 || nbusy !== 3) begin
      failures++; $display("FAIL muldiv_totals got stall=%0d start=%0d busy=%0d exp 4/1/3", nstall, nstart, nbusy);
    end
  endtask
  task automatic test_mem_wait();
    int nstall, nfreeze;
    do_reset();
    nstall = 0; nfreeze = 0;
    for (int i = 0; i < 10; i++) begin
      if (i >= 2 && i <= 4) apply(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      else if (i < 8) apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      else idle();
      checks++;
      if (act_o() !== exp_o) begin failures++; $display("FAIL memwait_cyc%0d got=%b exp=%b", i, act_o(), exp_o); end
      nstall += int'(pif.stall_pc);
      nfreeze += int'(act_o()[9:5] == 5'b11111);
    end
    checks++;
    if (nstall !== 7 || nfreeze !== 3 || int'(stall_cycles) !== 7) begin
      failures++; $display("FAIL memwait_totals got stall=%0d freeze=%0d cnt=%0d exp 7/3/7", nstall, nfreeze, stall_cycles);
    end
  endtask
  task automatic test_branch();
    do_reset();
    apply(5, 0, 5, 1, 0, 1, 0, 1, 0, 1);
    checks++;
    if (act_o() !== exp_o || act_o() !== 10'b0000_0110_00) begin
      failures++; $display("FAIL branch_vs_lu got=%b exp=%b", act_o(), exp_o);
    end
    idle();
    checks++;
    if (int'(flush_count) !== 1 || int'(stall_cycles) !== 0) begin
      failures++; $display("FAIL branch_count got=%0d/%0d exp=1/0", flush_count, stall_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 1, 1, i == 2);
      checks++;
      if (act_o() !== exp_o || pif.flush_fet_dec !== (i == 2)) begin
        failures++; $display("FAIL branch_memwait%0d got=%b exp=%b", i, act_o(), exp_o);
      end
    end
  endtask
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(3, 0, 3, 1, 0, 1, 0, 0, 0, 1);
      checks++;
      if (act_o() !== exp_o || int'(stall_cycles) !== exp_sc) begin
        failures++; $display("FAIL sat_cyc%0d got=%b cnt=%0d exp=%b cnt=%0d", i, act_o(), stall_cycles, exp_o, exp_sc);
      end
    end
    idle();
    checks++;
    if (int'(stall_cycles) !== 15) begin failures++; $display("FAIL sat_final got=%0d exp=15", stall_cycles); end
  endtask
  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    checks++;
    if (pif.muldiv_busy !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b exp=1", pif.muldiv_busy); end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (act_o() !== 10'd0 || stall_cycles !== '0 || flush_count !== '0) begin
      failures++; $display("FAIL midop_reset got=%b cnt=%0d/%0d exp=0", act_o(), stall_cycles, flush_count);
    end
    model_clear();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1;
    idle();
    checks++;
    if (act_o() !== exp_o || act_o() !== 10'd0) begin
      failures++; $display("FAIL midop_release got=%b exp=%b", act_o(), exp_o);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 1'($urandom));
      checks++;
      if (act_o() !== exp_o || int'(stall_cycles) !== exp_sc || int'(flush_count) !== exp_fc) begin
        failures++;
        $display("FAIL random_cyc%0d got=%b %0d/%0d exp=%b %0d/%0d", i, act_o(), stall_cycles, flush_count, exp_o, exp_sc, exp_fc);
      end
    end
  endtask
  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_clear();
    test_reset();
    test_load_use();
    test_muldiv();
    test_mem_wait();
    test_branch();
    test_saturation();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
